// File: rtl/alu_pkg.sv
// Shared opcode constants, sequencer state type and opcode classification helpers
// for the ALU control/capture stage.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT_MC,
    ST_DONE
  } state_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic uses_count(input logic [4:0] op);
    return (op == OP_ROR) || (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_rot_count.sv
// Derives the count fed to the rotate-right unit; ROL is mapped onto ROR by
// rotating right by (32 - n) mod 32.
module alu_rot_count
  import alu_pkg::*;
(
  input  logic [4:0] i_op,
  input  logic [4:0] i_b_count,
  output logic [4:0] o_count
);

  always_comb begin
    o_count = '0;
    if (i_op == OP_ROL) begin
      o_count = 5'd0 - i_b_count;
    end else if (uses_count(i_op)) begin
      o_count = i_b_count;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Latches ALU operation/operands, captures single-cycle results or handshakes
// with the MUL/DIV unit, and loads the ZHigh/ZLow pair.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned TO_W       = 7
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  op,
  input  logic [31:0] y_operand,
  input  logic [31:0] bus_operand,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [4:0]  unit_count,
  input  logic [31:0] sc_result,
  output logic        mc_start,
  input  logic        mc_done,
  input  logic [63:0] mc_result,
  output logic [31:0] z_high,
  output logic [31:0] z_low,
  output logic        z_zero,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t          r_state;
  state_t          w_next;
  logic [4:0]      r_op;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [4:0]      r_count;
  logic [31:0]     r_z_high;
  logic [31:0]     r_z_low;
  logic            r_z_zero;
  logic            r_err;
  logic [TO_W-1:0] r_cnt;
  logic [4:0]      w_count;
  logic            w_timeout;
  logic            w_mc_start;
  logic            w_busy;
  logic            w_done;

  alu_rot_count u_rot_count (
    .i_op      (op),
    .i_b_count (bus_operand[4:0]),
    .o_count   (w_count)
  );

  assign w_timeout = (r_cnt == TO_W'(MC_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_mc_start = 1'b0;
    w_busy     = (r_state != ST_IDLE);
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_multicycle(r_op)) begin
          w_mc_start = 1'b1;
          w_next     = ST_WAIT_MC;
        end else begin
          w_next = ST_DONE;
        end
      end
      ST_WAIT_MC: begin
        if (mc_done || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_z_high <= '0;
      r_z_low  <= '0;
      r_z_zero <= 1'b1;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= y_operand;
            r_b     <= bus_operand;
            r_count <= w_count;
            r_err   <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (is_multicycle(r_op)) begin
            r_cnt <= '0;
          end else if (is_legal(r_op)) begin
            r_z_low  <= sc_result;
            r_z_high <= '0;
            r_z_zero <= (sc_result == '0);
          end else begin
            r_err <= 1'b1;
          end
        end
        ST_WAIT_MC: begin
          // A result arriving on the final timeout cycle takes priority over the abort.
          if (mc_done) begin
            r_z_high <= mc_result[63:32];
            r_z_low  <= mc_result[31:0];
            r_z_zero <= (mc_result == '0);
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign unit_count = r_count;
  assign z_high     = r_z_high;
  assign z_low      = r_z_low;
  assign z_zero     = r_z_zero;
  assign err        = r_err;
  assign mc_start   = w_mc_start;
  assign busy       = w_busy;
  assign done       = w_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, directed multi-cycle
// corner cases and randomized operations against a behavioural model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned MC_TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  op;
  logic [31:0] y_operand;
  logic [31:0] bus_operand;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [4:0]  unit_count;
  logic [31:0] sc_result;
  logic        mc_start;
  logic        mc_done;
  logic [63:0] mc_result;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic        z_zero;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  int mc_pulses = 0;

  logic [4:0]  cur_op;
  logic [31:0] exp_zh;
  logic [31:0] exp_zl;
  logic        exp_zz;
  logic        exp_err;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  cnt;
    logic [31:0] z;
  } vec_t;

  vec_t vt[13];
  logic [4:0] sc_ops[11];

  alu_op_sequencer #(.MC_TIMEOUT(MC_TIMEOUT), .TO_W(7)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .y_operand   (y_operand),
    .bus_operand (bus_operand),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_count  (unit_count),
    .sc_result   (sc_result),
    .mc_start    (mc_start),
    .mc_done     (mc_done),
    .mc_result   (mc_result),
    .z_high      (z_high),
    .z_low       (z_low),
    .z_zero      (z_zero),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (mc_start === 1'b1) mc_pulses++;

  // Function units as seen by the sequencer: they consume its latched lines.
  function automatic logic [31:0] rotr(input logic [31:0] a, input logic [4:0] n);
    return (a >> n) | (a << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] fu(input logic [4:0] o, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] c);
    case (o)
      OP_ADD:         return a + b;
      OP_SUB:         return a - b;
      OP_AND:         return a & b;
      OP_OR:          return a | b;
      OP_SHR:         return a >> c;
      OP_SHRA:        return $signed(a) >>> c;
      OP_SHL:         return a << c;
      OP_ROR, OP_ROL: return rotr(a, c);
      OP_NEG:         return -a;
      OP_NOT:         return ~a;
      default:        return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign sc_result = fu(cur_op, unit_a, unit_b, unit_count);

  // Reference result straight from the operation's meaning on A and B[4:0].
  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [4:0] n;
    n = b[4:0];
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SHR:  return a >> n;
      OP_SHRA: return (a >> n) | (a[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0);
      OP_SHL:  return a << n;
      OP_ROR:  return (a >> n) | (a << (6'd32 - {1'b0, n}));
      OP_ROL:  return (a << n) | (a >> (6'd32 - {1'b0, n}));
      OP_NEG:  return 32'd0 - a;
      OP_NOT:  return a ^ 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] ref_count(input logic [4:0] o, input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
    if (o == OP_ROL) return 5'((32 - n) % 32);
    if (o == OP_ROR || o == OP_SHR || o == OP_SHRA || o == OP_SHL) return 5'(n);
    return 5'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op          = o;
    y_operand   = a;
    bus_operand = b;
    cur_op      = o;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    op          = 5'($urandom);
    y_operand   = $urandom;
    bus_operand = $urandom;
  endtask

  task automatic run_sc(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ecnt, input logic [31:0] ez);
    int p0;
    p0 = mc_pulses;
    issue(o, a, b);
    chk("exec_busy", 64'(busy), 64'(1'b1));
    chk("exec_done", 64'(done), 64'(1'b0));
    chk("exec_err_cleared", 64'(err), 64'(1'b0));
    chk("unit_a", 64'(unit_a), 64'(a));
    chk("unit_b", 64'(unit_b), 64'(b));
    chk("unit_count", 64'(unit_count), 64'(ecnt));
    tick();
    exp_zh = 32'h0; exp_zl = ez; exp_zz = (ez == 32'h0); exp_err = 1'b0;
    chk("sc_done", 64'(done), 64'(1'b1));
    chk("sc_busy", 64'(busy), 64'(1'b1));
    chk("sc_z_low", 64'(z_low), 64'(exp_zl));
    chk("sc_z_high", 64'(z_high), 64'(exp_zh));
    chk("sc_z_zero", 64'(z_zero), 64'(exp_zz));
    chk("sc_err", 64'(err), 64'(exp_err));
    tick();
    chk("sc_idle_busy", 64'(busy), 64'(1'b0));
    chk("sc_idle_done", 64'(done), 64'(1'b0));
    chk("sc_no_mc_start", 64'(mc_pulses - p0), 64'(0));
  endtask

  task automatic run_mc(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int d, input logic [63:0] res, input logic poke);
    int p0;
    int waited;
    int exp_wait;
    p0 = mc_pulses;
    issue(o, a, b);
    chk("mc_start_exec", 64'(mc_start), 64'(1'b1));
    chk("mc_exec_busy", 64'(busy), 64'(1'b1));
    tick();
    chk("mc_start_low", 64'(mc_start), 64'(1'b0));
    waited = 0;
    for (int k = 0; k < 200; k++) begin
      mc_done   = (k == d);
      mc_result = res;
      if (poke && k == 3) begin
        start = 1'b1;
        op    = OP_MUL;
      end
      tick();
      mc_done = 1'b0;
      start   = 1'b0;
      waited++;
      if (done === 1'b1) break;
    end
    exp_wait = (d < int'(MC_TIMEOUT)) ? d + 1 : int'(MC_TIMEOUT);
    chk("mc_wait_cycles", 64'(waited), 64'(exp_wait));
    if (d < int'(MC_TIMEOUT)) begin
      exp_zh = res[63:32]; exp_zl = res[31:0]; exp_zz = (res == 64'h0); exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    chk("mc_z_high", 64'(z_high), 64'(exp_zh));
    chk("mc_z_low", 64'(z_low), 64'(exp_zl));
    chk("mc_z_zero", 64'(z_zero), 64'(exp_zz));
    chk("mc_err", 64'(err), 64'(exp_err));
    tick();
    chk("mc_idle_busy", 64'(busy), 64'(1'b0));
    chk("mc_err_sticky", 64'(err), 64'(exp_err));
    chk("mc_start_pulses", 64'(mc_pulses - p0), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear = 1'b1; start = 1'b0; op = '0; y_operand = '0; bus_operand = '0;
    mc_done = 1'b0; mc_result = '0; cur_op = OP_ADD;
    tick();
    tick();
    exp_zh = '0; exp_zl = '0; exp_zz = 1'b1; exp_err = 1'b0;
    chk("rst_unit_a", 64'(unit_a), 64'(0));
    chk("rst_unit_b", 64'(unit_b), 64'(0));
    chk("rst_unit_count", 64'(unit_count), 64'(0));
    chk("rst_z", {z_high, z_low}, 64'(0));
    chk("rst_z_zero", 64'(z_zero), 64'(1'b1));
    chk("rst_status", 64'({mc_start, busy, done, err}), 64'(0));
    clear = 1'b0;
    tick();

    vt[0]  = '{OP_ROR,  32'h8000_0001, 32'd4,          5'd4,  32'h1800_0000};
    vt[1]  = '{OP_ROL,  32'h8000_0001, 32'd4,          5'd28, 32'h0000_0018};
    vt[2]  = '{OP_ROL,  32'h8000_0001, 32'd0,          5'd0,  32'h8000_0001};
    vt[3]  = '{OP_ADD,  32'd5,         32'd7,          5'd0,  32'h0000_000C};
    vt[4]  = '{OP_SUB,  32'd3,         32'd3,          5'd0,  32'h0000_0000};
    vt[5]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,  5'd0,  32'hF000_F000};
    vt[6]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000,  5'd0,  32'hFFFF_F0F0};
    vt[7]  = '{OP_SHR,  32'hF000_0000, 32'h0000_0024,  5'd4,  32'h0F00_0000};
    vt[8]  = '{OP_SHRA, 32'h8000_0000, 32'd31,         5'd31, 32'hFFFF_FFFF};
    vt[9]  = '{OP_SHL,  32'h0000_0001, 32'd31,         5'd31, 32'h8000_0000};
    vt[10] = '{OP_NEG,  32'h0000_0001, 32'd7,          5'd0,  32'hFFFF_FFFF};
    vt[11] = '{OP_NOT,  32'h0000_0000, 32'd5,          5'd0,  32'hFFFF_FFFF};
    vt[12] = '{OP_ROL,  32'h0000_0001, 32'd1,          5'd31, 32'h0000_0002};
    for (int i = 0; i < 13; i++) run_sc(vt[i].op, vt[i].a, vt[i].b, vt[i].cnt, vt[i].z);

    run_mc(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32, 64'h0000_0001_FFFF_FFFE, 1'b1);
    run_mc(OP_DIV, 32'd100, 32'd7, 1000, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    run_mc(OP_DIV, 32'd100, 32'd7, int'(MC_TIMEOUT) - 1, 64'h0000_0002_0000_000E, 1'b0);

    // Illegal opcode, then a start during DONE that must not be taken.
    issue(5'b11111, 32'h5555_AAAA, 32'h1);
    chk("ill_exec_err", 64'(err), 64'(1'b0));
    tick();
    chk("ill_done", 64'(done), 64'(1'b1));
    chk("ill_err", 64'(err), 64'(1'b1));
    chk("ill_z", {z_high, z_low}, {exp_zh, exp_zl});
    op = OP_ADD; y_operand = 32'h1111_1111; bus_operand = 32'h2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored", 64'(busy), 64'(1'b0));
    tick();
    chk("done_start_ignored2", 64'(busy), 64'(1'b0));
    chk("ill_err_sticky", 64'(err), 64'(1'b1));
    chk("ill_unit_a_held", 64'(unit_a), 64'(32'h5555_AAAA));

    sc_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
               OP_ROR, OP_ROL, OP_NEG, OP_NOT};
    for (int i = 0; i < 30; i++) begin
      logic [4:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      o = sc_ops[$urandom_range(0, 10)];
      a = $urandom;
      b = $urandom;
      if (i % 7 == 0) b[4:0] = 5'd0;
      run_sc(o, a, b, ref_count(o, b), ref_result(o, a, b));
    end
    for (int i = 0; i < 6; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      run_mc(($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV, $urandom, $urandom,
             int'($urandom_range(0, 80)), r, 1'(i % 2));
    end

    // Reset while waiting on MUL/DIV; a late mc_done must be ignored.
    issue(OP_MUL, 32'h7, 32'h9);
    tick();
    tick();
    tick();
    chk("pre_reset_busy", 64'(busy), 64'(1'b1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_zh = '0; exp_zl = '0; exp_zz = 1'b1; exp_err = 1'b0;
    chk("midrst_busy", 64'(busy), 64'(1'b0));
    chk("midrst_z", {z_high, z_low}, 64'(0));
    chk("midrst_z_zero", 64'(z_zero), 64'(1'b1));
    chk("midrst_unit_a", 64'(unit_a), 64'(0));
    chk("midrst_err", 64'(err), 64'(1'b0));
    mc_done = 1'b1; mc_result = 64'hFFFF_0000_1234_5678;
    tick();
    mc_done = 1'b0;
    tick();
    chk("late_mc_done_z", {z_high, z_low}, 64'(0));
    chk("late_mc_done_status", 64'({busy, done, z_zero}), 64'(3'b001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control/capture stage wrapped around the ALU function units, including the 32-bit rotate-right unit.
- Latches the operation and operands, and drives the operand and rotate-count lines the function units consume.
- Captures single-cycle results, or handshakes with the multi-cycle MUL/DIV unit, and loads the 64-bit Z register pair (ZHigh/ZLow).
- Reports busy/done/error status to the control unit.

Parameters:
MC_TIMEOUT, 64, max cycles to wait for mc_done before aborting with error
TO_W, 7, width of timeout counter (must hold MC_TIMEOUT)

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  reset; one clock; reset is synchronous and active-high
start  in  1  single-cycle pulse requesting an operation
op  in  5  ALU opcode (package constants)
y_operand  in  32  operand A (Y register)
bus_operand  in  32  operand B (bus); B[4:0] is the shift/rotate count
unit_a  out  32  latched A to function units
unit_b  out  32  latched B to function units
unit_count  out  5  rotate count to the rotate-right unit's num_rotates input
sc_result  in  32  single-cycle function-unit result (external mux selected by op)
mc_start  out  1  one-cycle start pulse to MUL/DIV unit
mc_done  in  1  MUL/DIV result valid (single-cycle pulse)
mc_result  in  64  MUL/DIV result {high, low}
z_high  out  32  ZHigh register
z_low  out  32  ZLow register
z_zero  out  1  registered: last captured Z value is zero
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when Z updated or op aborted
err  out  1  sticky until next accepted start: illegal op or timeout

Behaviour:
- States: IDLE, EXEC, WAIT_MC, DONE.
- Reset (clear=1 at a clock edge, any state, including mid-op):
  - state=IDLE.
  - z_high, z_low, unit_a, unit_b = 0; unit_count = 0.
  - z_zero=1; mc_start, busy, done, err = 0.
  - Timeout counter = 0.
- IDLE, start=1:
  - Latch op, unit_a=y_operand, unit_b=bus_operand; clear err.
  - unit_count = B[4:0] for ROR, SHR, SHRA, SHL; for ROL, (32 - B[4:0]) mod 32, so the ROR unit serves ROL (B[4:0]=0 gives 0); otherwise 0.
  - Next state EXEC.
- start outside IDLE is ignored; no queueing.
- EXEC, single-cycle ops (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT):
  - z_low <= sc_result; z_high <= 0; z_zero <= (sc_result==0).
  - Next state DONE.
- EXEC, MUL/DIV:
  - mc_start=1 for exactly this cycle; timeout counter <= 0.
  - Next state WAIT_MC.
- EXEC, any other opcode: err <= 1; Z unchanged; next state DONE.
- WAIT_MC:
  - Counter increments each cycle.
  - mc_done=1: {z_high, z_low} <= mc_result; z_zero <= (mc_result==0); next state DONE.
  - Else, counter reaching MC_TIMEOUT-1: err <= 1; Z unchanged; next state DONE.
  - mc_done in the same cycle as the timeout hit: mc_done wins and the result is captured.
- DONE: done=1 for one cycle; next state IDLE. start in this cycle is ignored.
- Latency:
  - Single-cycle op: start at edge N, Z valid and done=1 in cycle N+2.
  - MUL/DIV: done in the cycle after the mc_done cycle.
- unit_a, unit_b and unit_count hold stable from EXEC until the next accepted start.
- sc_result is sampled only in EXEC.
- mc_done outside WAIT_MC is ignored.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
  - State encoding.
  - is_multicycle/is_legal helper functions.
- Optional sub-module alu_rot_count: combinational count derivation (ROL two's-complement mapping).

Test Plan:
- ROR: clear, then start with op=ROR, A=0x8000_0001, B=4; bench ROR model on unit_a/unit_count -> unit_count=4, z_low=0x1800_0000, z_high=0, done in cycle N+2, busy in N+1..N+2.
- ROL: op=ROL, A=0x8000_0001, B=4 -> unit_count=28, z_low=0x0000_0018. Also B=0 -> unit_count=0, z_low=A.
- MUL handshake: op=MUL, mc_done after 32 cycles with mc_result=0x0000_0001_FFFF_FFFE -> mc_start exactly one cycle, z_high=0x1, z_low=0xFFFF_FFFE, z_zero=0, err=0.
- Timeout: op=DIV, mc_done never asserted -> done after MC_TIMEOUT cycles in WAIT_MC, err=1, Z unchanged.
- Timeout boundary: mc_done asserted on the final timeout cycle -> result captured, err=0.
- Illegal op / start while busy: op=11111 -> err=1, Z unchanged. start pulses during WAIT_MC are ignored (no second mc_start).
- Reset mid-op: clear asserted in WAIT_MC -> next cycle IDLE, Z=0, z_zero=1, busy=0. A later mc_done is ignored.
